time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/clock_ctrl_pkg.sv | 55 +++++
 rtl/key_debounce.sv | 68 ++++++
 rtl/time_set_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared definitions for the MM:SS time-set controller:
//   mode_t        - controller state, also driven out on MODE
//   BCD_*_MAX     - largest legal ones / tens digit of a 00..59 field
//   KEY_*         - bit index of each pushbutton within KEY
//   bcd2_t        - one two-digit BCD field (minutes or seconds)
//   bcd60_inc     - add 1 to a 00..59 BCD field, wrapping 59 -> 00
//   bcd60_max     - true when a field reads 59
// -----------------------------------------------------------------------------
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STOP    = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_t;

    localparam logic [3:0] BCD_ONES_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX = 4'd5;

    localparam int KEY_MODE = 0;
    localparam int KEY_INC  = 1;
    localparam int KEY_RUN  = 2;
    localparam int KEY_CLR  = 3;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    function automatic logic bcd60_max(input bcd2_t v);
        return (v.tens == BCD_TENS_MAX) && (v.ones == BCD_ONES_MAX);
    endfunction

    // The >= compares make an out-of-range digit fall back into range on
    // the next increment instead of counting through invalid codes.
    function automatic bcd2_t bcd60_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones >= BCD_ONES_MAX) begin
            r.ones = 4'd0;
            if (v.tens >= BCD_TENS_MAX) begin
                r.tens = 4'd0;
            end else begin
                r.tens = v.tens + 4'd1;
            end
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One active-low pushbutton: 2-flop synchronizer, then a debouncer that
// accepts a new level only after it has been stable for DEBOUNCE_CYCLES
// cycles. press is a one-cycle pulse on the accepted 1->0 transition.
//
// A press is only reported once the key has been seen released since reset,
// so a button held through reset does not fire on its way out.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   key_raw  in   asynchronous pushbutton level (0 = pressed)
//   press    out  one-cycle press event
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [1:0]       fill;     // sync2 carries a real sample once fill[1] is set
    logic             armed;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // NOTE: every flop here uses <= so all of them sample the same pre-edge
    // values; blocking assignments would collapse the synchronizer chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            press <= 1'b0;

            if (fill[1] && sync2) begin
                armed <= 1'b1;
            end

            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= armed & ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// MM:SS clock with four pushbuttons: run/stop, set minutes, set seconds,
// clear. Time advances once per CLK_HZ cycles while in RUN.
//
// Build option: define BLINK_EN to blink the digits being edited
// (DIG_BLANK toggles every CLK_HZ/4 cycles); otherwise DIG_BLANK is 0.
//
// Ports
//   CLK                 in   clock, rising edge
//   RST_N               in   synchronous active-low reset
//   KEY[3:0]            in   active-low buttons: [0] mode, [1] inc,
//                            [2] start/stop, [3] clear
//   SEC_ONES..MIN_TENS  out  BCD time digits
//   MODE[1:0]           out  RUN=0, STOP=1, SET_MIN=2, SET_SEC=3
//   TICK                out  one-cycle pulse on each 1 s advance
//   ROLLOVER            out  one-cycle pulse on 59:59 -> 00:00
//   DIG_BLANK[3:0]      out  blank request, [3:2] minutes, [1:0] seconds
// -----------------------------------------------------------------------------
module time_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] KEY,
    output logic [3:0] SEC_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] MIN_ONES,
    output logic [3:0] MIN_TENS,
    output logic [1:0] MODE,
    output logic       TICK,
    output logic       ROLLOVER,
    output logic [3:0] DIG_BLANK
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    // ---------------------------------------------------------------- keys
    logic [3:0] key_press;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk    (CLK),
            .rst_n  (RST_N),
            .key_raw(KEY[i]),
            .press  (key_press[i])
        );
    end

    // One event per cycle: clear > mode > start/stop > increment.
    logic ev_clr, ev_mode, ev_run, ev_inc;

    assign ev_clr  = key_press[KEY_CLR];
    assign ev_mode = key_press[KEY_MODE] & ~ev_clr;
    assign ev_run  = key_press[KEY_RUN]  & ~ev_clr & ~key_press[KEY_MODE];
    assign ev_inc  = key_press[KEY_INC]  & ~ev_clr & ~key_press[KEY_MODE]
                                         & ~key_press[KEY_RUN];

    // ----------------------------------------------------------------- FSM
    mode_t state, state_nx;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: state_nx gets its default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        if (ev_mode) begin
            case (state)
                RUN, STOP: state_nx = SET_MIN;
                SET_MIN:   state_nx = SET_SEC;
                SET_SEC:   state_nx = STOP;
                default:   state_nx = RUN;
            endcase
        end else if (ev_run) begin
            case (state)
                RUN:     state_nx = STOP;
                STOP:    state_nx = RUN;
                default: state_nx = state;
            endcase
        end
    end

    assign MODE = state;

    // ------------------------------------------------------ time datapath
    bcd2_t         sec, mins;
    logic [PW-1:0] presc;
    logic          tick_now, roll_now, enter_set_min;

    assign enter_set_min = (state_nx == SET_MIN) && (state != SET_MIN);
    // A clear in the same cycle swallows the advance and both pulses.
    assign tick_now = (state == RUN) && (presc == PRESC_LAST) && !ev_clr;
    assign roll_now = tick_now && bcd60_max(sec) && bcd60_max(mins);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sec      <= '0;
            mins     <= '0;
            presc    <= '0;
            TICK     <= 1'b0;
            ROLLOVER <= 1'b0;
        end else begin
            TICK     <= tick_now;
            ROLLOVER <= roll_now;
            if (ev_clr) begin
                sec   <= '0;
                mins  <= '0;
                presc <= '0;
            end else begin
                // Zeroing on SET_MIN entry gives a full second after RUN resumes.
                if (enter_set_min) begin
                    presc <= '0;
                end else if (state == RUN) begin
                    presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                end

                if (tick_now) begin
                    sec <= bcd60_inc(sec);
                    if (bcd60_max(sec)) begin
                        mins <= bcd60_inc(mins);
                    end
                end else if (ev_inc && (state == SET_MIN)) begin
                    mins <= bcd60_inc(mins);
                end else if (ev_inc && (state == SET_SEC)) begin
                    sec <= bcd60_inc(sec);
                end
            end
        end
    end

    assign SEC_ONES = sec.ones;
    assign SEC_TENS = sec.tens;
    assign MIN_ONES = mins.ones;
    assign MIN_TENS = mins.tens;

    // --------------------------------------------------------------- blink
`ifdef BLINK_EN
    localparam int BLINK_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt;
    logic          blank_phase;
    logic          in_set, set_entry;

    assign in_set    = (state == SET_MIN) || (state == SET_SEC);
    assign set_entry = (state_nx != state) &&
                       ((state_nx == SET_MIN) || (state_nx == SET_SEC));

    // Phase restarts visible on entry and on every edit so the new value is
    // shown immediately.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            blink_cnt   <= '0;
            blank_phase <= 1'b0;
        end else if (!in_set || set_entry || ev_inc) begin
            blink_cnt   <= '0;
            blank_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blank_phase <= ~blank_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        DIG_BLANK = 4'b0000;
        if (blank_phase) begin
            if (state == SET_MIN) begin
                DIG_BLANK = 4'b1100;
            end else if (state == SET_SEC) begin
                DIG_BLANK = 4'b0011;
            end
        end
    end
`else
    assign DIG_BLANK = 4'b0000;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed bench for time_set_ctrl with CLK_HZ=8, DEBOUNCE_CYCLES=4.
// A table of single-key steps covers the mode/edit behaviour; hand-written
// sequences cover tick timing, minute wrap, rollover, coincident keys and
// reset with a held key. Time is compared as 16'hMMSS in BCD.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;
    import clock_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] KEY = 4'hF;
    logic [3:0] SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS;
    logic [1:0] MODE;
    logic       TICK, ROLLOVER;
    logic [3:0] DIG_BLANK;

    time_set_ctrl #(
        .CLK_HZ         (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .KEY      (KEY),
        .SEC_ONES (SEC_ONES),
        .SEC_TENS (SEC_TENS),
        .MIN_ONES (MIN_ONES),
        .MIN_TENS (MIN_TENS),
        .MODE     (MODE),
        .TICK     (TICK),
        .ROLLOVER (ROLLOVER),
        .DIG_BLANK(DIG_BLANK)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [15:0] digits();
        return {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES};
    endfunction

    task automatic press_key(input int k, input int low, input int gap);
        KEY[k] = 1'b0;
        cycles(low);
        KEY[k] = 1'b1;
        cycles(gap);
    endtask

    task automatic press_n(input int k, input int n);
        repeat (n) press_key(k, 8, 8);
    endtask

    // From STOP: press start/stop, count cycles from MODE turning RUN to the
    // first TICK, and capture ROLLOVER in that same cycle.
    task automatic start_and_time(output int since, output logic roll_seen);
        bit entered;
        entered   = 1'b0;
        since     = -1;
        roll_seen = 1'b0;
        KEY[KEY_RUN] = 1'b0;
        for (int c = 0; c < 60; c++) begin
            cycles(1);
            if (c == 7) KEY[KEY_RUN] = 1'b1;
            if (entered) begin
                since++;
                if (TICK) begin
                    roll_seen = ROLLOVER;
                    break;
                end
            end else if (MODE == 2'd0) begin
                entered = 1'b1;
                since   = 0;
            end
        end
        KEY[KEY_RUN] = 1'b1;
    endtask

    typedef struct {
        int          key;
        int          low;
        logic [1:0]  mode;
        logic [15:0] tval;
        string       name;
    } vec_t;

    vec_t vecs[15];
    int   nv = 0;

    task automatic add_vec(input int key, input int low, input logic [1:0] mode,
                           input logic [15:0] tval, input string name);
        vecs[nv].key  = key;
        vecs[nv].low  = low;
        vecs[nv].mode = mode;
        vecs[nv].tval = tval;
        vecs[nv].name = name;
        nv++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tick_err;
        int   tick_cnt;
        int   since;
        int   bad_mode;
        logic roll;

        add_vec(KEY_MODE, 8,  2'd2, 16'h0003, "run_to_set_min");
        add_vec(KEY_INC,  2,  2'd2, 16'h0003, "inc_glitch_ignored");
        add_vec(KEY_INC,  10, 2'd2, 16'h0103, "inc_min_once");
        add_vec(KEY_INC,  8,  2'd2, 16'h0203, "inc_min_again");
        add_vec(KEY_MODE, 8,  2'd3, 16'h0203, "set_min_to_set_sec");
        add_vec(KEY_RUN,  8,  2'd3, 16'h0203, "run_ignored_in_set_sec");
        add_vec(KEY_INC,  8,  2'd3, 16'h0204, "inc_sec");
        add_vec(KEY_MODE, 8,  2'd1, 16'h0204, "set_sec_to_stop");
        add_vec(KEY_INC,  8,  2'd1, 16'h0204, "inc_ignored_in_stop");
        add_vec(KEY_CLR,  8,  2'd1, 16'h0000, "clear_in_stop");
        add_vec(KEY_MODE, 8,  2'd2, 16'h0000, "stop_to_set_min");
        add_vec(KEY_INC,  8,  2'd2, 16'h0100, "inc_min_after_clear");
        add_vec(KEY_CLR,  8,  2'd2, 16'h0000, "clear_keeps_set_min");
        add_vec(KEY_MODE, 8,  2'd3, 16'h0000, "to_set_sec_2");
        add_vec(KEY_MODE, 8,  2'd1, 16'h0000, "to_stop_2");

        // ---- reset state
        cycles(3);
        check("rst_mode",     MODE,      2'd0);
        check("rst_digits",   digits(),  16'h0000);
        check("rst_tick",     TICK,      1'b0);
        check("rst_rollover", ROLLOVER,  1'b0);
        check("rst_blank",    DIG_BLANK, 4'h0);

        // ---- free run: TICK on edges 8, 16, 24 after release
        RST_N    = 1'b1;
        tick_err = 0;
        tick_cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            cycles(1);
            if (TICK !== ((i % 8) == 0)) tick_err++;
            if (TICK === 1'b1) tick_cnt++;
        end
        check("tick_spacing_errors", tick_err, 0);
        check("tick_count_24",       tick_cnt, 3);
        check("digits_after_24",     digits(), 16'h0003);

        // ---- table of single-key steps
        for (int i = 0; i < nv; i++) begin
            press_key(vecs[i].key, vecs[i].low, 10);
            check({vecs[i].name, "_mode"}, MODE,     vecs[i].mode);
            check({vecs[i].name, "_time"}, digits(), vecs[i].tval);
`ifndef BLINK_EN
            check({vecs[i].name, "_blank"}, DIG_BLANK, 4'h0);
`endif
        end

        // ---- STOP -> RUN, first TICK a full second later
        start_and_time(since, roll);
        check("stop_to_run_tick_delay", since,    8);
        check("first_tick_no_rollover", roll,     1'b0);
        check("first_tick_digits",      digits(), 16'h0001);
        press_key(KEY_RUN, 8, 10);
        check("run_to_stop", MODE, 2'd1);
        press_key(KEY_CLR, 8, 10);
        check("clear_after_stop", digits(), 16'h0000);

        // ---- minute wrap leaves seconds alone
        press_key(KEY_MODE, 8, 8);
        press_key(KEY_MODE, 8, 8);
        press_n(KEY_INC, 1);
        press_key(KEY_MODE, 8, 8);
        press_key(KEY_MODE, 8, 8);
        check("back_in_set_min", MODE, 2'd2);
        press_n(KEY_INC, 59);
        check("min_59", digits(), 16'h5901);
        press_n(KEY_INC, 1);
        check("min_wrap_keeps_sec", digits(), 16'h0001);

        // ---- preload 59:59 and roll over
        press_n(KEY_INC, 59);
        press_key(KEY_MODE, 8, 8);
        press_n(KEY_INC, 58);
        check("preload_5959", digits(), 16'h5959);
        press_key(KEY_MODE, 8, 8);
        check("preload_stop", MODE, 2'd1);
        start_and_time(since, roll);
        check("rollover_tick_delay",   since,    8);
        check("rollover_with_tick",    roll,     1'b1);
        check("rollover_digits",       digits(), 16'h0000);
        cycles(1);
        check("rollover_one_cycle",    ROLLOVER, 1'b0);
        check("tick_one_cycle",        TICK,     1'b0);

        // ---- clear and increment accepted in the same cycle in SET_SEC
        press_key(KEY_MODE, 8, 8);
        press_key(KEY_CLR, 8, 8);
        check("set_min_cleared", digits(), 16'h0000);
        press_key(KEY_MODE, 8, 8);
        press_n(KEY_INC, 37);
        check("sec_37", digits(), 16'h0037);
        KEY[KEY_CLR] = 1'b0;
        KEY[KEY_INC] = 1'b0;
        cycles(8);
        KEY = 4'hF;
        cycles(10);
        check("clr_beats_inc_time", digits(), 16'h0000);
        check("clr_beats_inc_mode", MODE,     2'd3);

        // ---- reset in SET_MIN at 12:34 with mode key held
        press_n(KEY_INC, 34);
        press_key(KEY_MODE, 8, 8);
        press_key(KEY_MODE, 8, 8);
        press_n(KEY_INC, 12);
        check("preload_1234", digits(), 16'h1234);
        check("preload_1234_mode", MODE, 2'd2);
        KEY[KEY_MODE] = 1'b0;
        cycles(4);
        RST_N = 1'b0;
        cycles(1);
        RST_N = 1'b1;
        check("midrun_reset_mode",   MODE,     2'd0);
        check("midrun_reset_digits", digits(), 16'h0000);
        bad_mode = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (MODE !== 2'd0) bad_mode++;
        end
        check("held_key_no_event", bad_mode, 0);
        KEY[KEY_MODE] = 1'b1;
        cycles(10);
        check("release_no_event", MODE, 2'd0);
        press_key(KEY_MODE, 8, 10);
        check("repress_event", MODE, 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
